// File: rtl/b06_datapath_if.sv
// b06 datapath bus: controller strobes in, compare/count/event results out.
// master drives the controller side and reads results; slave is the datapath.
interface b06_datapath_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       cc_mux;
  logic [1:0]       uscite;
  logic             enable_count;
  logic             ackout;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             eql;
  logic             cont_eql;
  logic [WIDTH-1:0] count;
  logic [1:0]       evt_data;
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_overflow;
  logic             ack_pulse;

  modport master (
    output cc_mux, uscite, enable_count,
    output ackout, data_in, data_valid,
    output evt_ready,
    input  eql, cont_eql, count,
    input  evt_data, evt_valid,
    input  evt_overflow, ack_pulse
  );

  modport slave (
    input  cc_mux, uscite, enable_count,
    input  ackout, data_in, data_valid,
    input  evt_ready,
    output eql, cont_eql, count,
    output evt_data, evt_valid,
    output evt_overflow, ack_pulse
  );
endinterface

// File: rtl/b06_datapath.sv
// b06 datapath: saturating counter, operand compare, uscite event FIFO.
// Ports: clock, reset (async high), bus (b06_datapath_if.slave).
module b06_datapath #(
  parameter int               WIDTH = 8,
  parameter int               TERM  = 12,
  parameter logic [WIDTH-1:0] REF_A = 8'h55,
  parameter logic [WIDTH-1:0] REF_B = 8'hAA,
  parameter int               DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  b06_datapath_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);
  localparam logic [AW:0] FULL_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] count_q;
  logic             eql_q;
  logic             ack_q;
  logic             pulse_q;
  logic             ovf_q;
  logic [1:0]       last_u_q;
  logic [1:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      occ_q;

  logic cmp;
  logic push;
  logic pop;
  logic full;
  logic accept;
  logic empty;

  assign empty  = occ_q == '0;
  assign full   = occ_q == FULL_V;
  assign pop    = ~empty & bus.evt_ready;
  assign push   = bus.uscite != last_u_q;
  // A full FIFO still takes a push when the head leaves
  assign accept = push & (~full | pop);

  always_comb begin
    cmp = 1'b0;
    unique case (bus.cc_mux)
      2'b00: cmp = 1'b0;
      2'b01: cmp = cap_q == REF_A;
      2'b10: cmp = cap_q == count_q;
      2'b11: cmp = cap_q == REF_B;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_q    <= '0;
      count_q  <= '0;
      eql_q    <= 1'b0;
      ack_q    <= 1'b0;
      pulse_q  <= 1'b0;
      ovf_q    <= 1'b0;
      last_u_q <= 2'b00;
      wr_q     <= '0;
      rd_q     <= '0;
      occ_q    <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= 2'b00;
    end else begin
      if (bus.data_valid)
        cap_q <= bus.data_in;

      if (!bus.enable_count)
        count_q <= '0;
      else if (count_q != TERM_V)
        count_q <= count_q + WIDTH'(1);

      eql_q <= cmp;

      last_u_q <= bus.uscite;
      if (accept) begin
        mem_q[wr_q] <= bus.uscite;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop)
        rd_q <= rd_q + AW'(1);
      occ_q <= occ_q + (AW+1)'(accept)
                     - (AW+1)'(pop);
      if (push && full && !pop)
        ovf_q <= 1'b1;

      ack_q   <= bus.ackout;
      pulse_q <= bus.ackout & ~ack_q;
    end
  end

  assign bus.count        = count_q;
  assign bus.cont_eql     = count_q == TERM_V;
  assign bus.eql          = eql_q;
  assign bus.evt_valid    = ~empty;
  // Stale slots are masked so an empty FIFO reads 00
  assign bus.evt_data     = empty ? 2'b00 : mem_q[rd_q];
  assign bus.evt_overflow = ovf_q;
  assign bus.ack_pulse    = pulse_q;
endmodule
